// File: rtl/frecuencia_pkg.sv
// rtl/frecuencia_pkg.sv - shared types and saturating arithmetic for the frequency setpoint
package frecuencia_pkg;

  typedef enum logic [1:0] {LIBRE, PULSADO, REPITE} estado_t;

  // Operands are zero-extended from the setpoint width; one guard bit catches carry/borrow.
  localparam int FW = 32;

  function automatic logic [FW-1:0] suma_sat(input logic [FW-1:0] a,
                                             input logic [FW-1:0] b,
                                             input logic [FW-1:0] tope);
    logic [FW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, tope}) ? tope : s[FW-1:0];
  endfunction

  function automatic logic [FW-1:0] resta_sat(input logic [FW-1:0] a,
                                              input logic [FW-1:0] b,
                                              input logic [FW-1:0] piso);
    logic [FW:0] d;
    d = {1'b0, a} - {1'b0, b};
    return (d[FW] || (d[FW-1:0] < piso)) ? piso : d[FW-1:0];
  endfunction

  function automatic logic [FW-1:0] limita(input logic [FW-1:0] v,
                                           input logic [FW-1:0] piso,
                                           input logic [FW-1:0] tope);
    if (v < piso) return piso;
    if (v > tope) return tope;
    return v;
  endfunction

endpackage

// File: rtl/frecuencia_consigna_boton_antirrebote.sv
// rtl/frecuencia_consigna_boton_antirrebote.sv - button synchroniser, debounce and hold-to-repeat
module boton_antirrebote
  import frecuencia_pkg::*;
#(
  parameter int DEB_CICLOS  = 500000,
  parameter int REP_RETARDO = 25000000,
  parameter int REP_PERIODO = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic boton,
  output logic evento
);

  localparam int DW   = $clog2(DEB_CICLOS + 1);
  localparam int RMAX = (REP_RETARDO > REP_PERIODO) ? REP_RETARDO : REP_PERIODO;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DEB_FIN = DW'(DEB_CICLOS - 1);
  localparam logic [RW-1:0] RET_FIN = RW'((REP_RETARDO > 0) ? REP_RETARDO - 1 : 0);
  localparam logic [RW-1:0] PER_FIN = RW'(REP_PERIODO - 1);

  logic          s1, s2, estable;
  logic [DW-1:0] cnt_deb;
  logic [RW-1:0] cnt_rep;
  estado_t       estado;
  logic          confirma;

  // The debounced state flips on this cycle; the FSM reacts on the same edge.
  assign confirma = (s2 != estable) && (cnt_deb == DEB_FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      estable <= 1'b1;
      cnt_deb <= '0;
      cnt_rep <= '0;
      estado  <= LIBRE;
      evento  <= 1'b0;
    end else begin
      s1     <= boton;
      s2     <= s1;
      evento <= 1'b0;

      if (s2 == estable)  cnt_deb <= '0;
      else if (confirma) begin
        cnt_deb <= '0;
        estable <= s2;
      end else            cnt_deb <= cnt_deb + 1'b1;

      if (confirma && !s2) begin
        estado  <= PULSADO;
        cnt_rep <= '0;
        evento  <= 1'b1;
      end else if (confirma && s2) begin
        estado  <= LIBRE;
        cnt_rep <= '0;
      end else begin
        case (estado)
          PULSADO: if (REP_RETARDO != 0) begin
            if (cnt_rep == RET_FIN) begin
              estado  <= REPITE;
              cnt_rep <= '0;
              evento  <= 1'b1;
            end else cnt_rep <= cnt_rep + 1'b1;
          end
          REPITE: begin
            if (cnt_rep == PER_FIN) begin
              cnt_rep <= '0;
              evento  <= 1'b1;
            end else cnt_rep <= cnt_rep + 1'b1;
          end
          default: cnt_rep <= '0;
        endcase
      end
    end
  end

endmodule

// File: rtl/frecuencia_consigna.sv
// rtl/frecuencia_consigna.sv - clamped frequency setpoint driven by buttons and UART loads
module frecuencia_consigna
  import frecuencia_pkg::*;
#(
  parameter int ANCHO       = 8,
  parameter int F_DEFECTO   = 60,
  parameter int F_MIN       = 1,
  parameter int F_MAX       = 200,
  parameter int PASO_FINO   = 1,
  parameter int PASO_GRUESO = 10,
  parameter int DEB_CICLOS  = 500000,
  parameter int REP_RETARDO = 25000000,
  parameter int REP_PERIODO = 5000000
) (
  input  logic             clock,
  input  logic             Restablecer,
  input  logic             Aumenta,
  input  logic             Disminuye,
  input  logic             Paso,
  input  logic             Selec,
  input  logic [ANCHO-1:0] Rx,
  input  logic             Rx_valido,
  output logic [ANCHO-1:0] Frec,
  output logic             Frec_act,
  output logic             Limite
);

  if (F_MIN > F_DEFECTO || F_DEFECTO > F_MAX || F_MAX > (2 ** ANCHO) - 1 ||
      PASO_FINO < 1 || PASO_GRUESO < 1 || DEB_CICLOS < 1 || REP_PERIODO < 1) begin : g_param_error
    $fatal(1, "frecuencia_consigna: invalid parameter set");
  end

  localparam logic [ANCHO-1:0] V_MIN = ANCHO'(F_MIN);
  localparam logic [ANCHO-1:0] V_MAX = ANCHO'(F_MAX);

  logic             paso_m, paso_s;
  logic             ev_up, ev_dn;
  logic [FW-1:0]    paso_v;
  logic [ANCHO-1:0] frec_sig;

  always_ff @(posedge clock or negedge Restablecer) begin
    if (!Restablecer) begin
      paso_m <= 1'b1;
      paso_s <= 1'b1;
    end else begin
      paso_m <= Paso;
      paso_s <= paso_m;
    end
  end

  boton_antirrebote #(
    .DEB_CICLOS(DEB_CICLOS), .REP_RETARDO(REP_RETARDO), .REP_PERIODO(REP_PERIODO)
  ) u_aumenta (
    .clk(clock), .rst_n(Restablecer), .boton(Aumenta), .evento(ev_up)
  );

  boton_antirrebote #(
    .DEB_CICLOS(DEB_CICLOS), .REP_RETARDO(REP_RETARDO), .REP_PERIODO(REP_PERIODO)
  ) u_disminuye (
    .clk(clock), .rst_n(Restablecer), .boton(Disminuye), .evento(ev_dn)
  );

  // A UART load wins outright; opposing step events in one cycle cancel.
  always_comb begin
    paso_v   = paso_s ? FW'(PASO_GRUESO) : FW'(PASO_FINO);
    frec_sig = Frec;
    if (Selec && Rx_valido)
      frec_sig = ANCHO'(limita(FW'(Rx), FW'(F_MIN), FW'(F_MAX)));
    else if (ev_up && !ev_dn)
      frec_sig = ANCHO'(suma_sat(FW'(Frec), paso_v, FW'(F_MAX)));
    else if (ev_dn && !ev_up)
      frec_sig = ANCHO'(resta_sat(FW'(Frec), paso_v, FW'(F_MIN)));
  end

  always_ff @(posedge clock or negedge Restablecer) begin
    if (!Restablecer) begin
      Frec     <= ANCHO'(F_DEFECTO);
      Frec_act <= 1'b0;
      Limite   <= (F_DEFECTO == F_MIN) || (F_DEFECTO == F_MAX);
    end else begin
      Frec     <= frec_sig;
      Frec_act <= (frec_sig != Frec);
      Limite   <= (frec_sig == V_MIN) || (frec_sig == V_MAX);
    end
  end

endmodule
